// File: rtl/xfer_ctrl_pkg.sv
// Shared types and constants for the transfer-register strobe sequencer.
package xfer_ctrl_pkg;

    localparam int MAX_REGS = 16;

    // Strobes are active low, so the quiescent vector is all ones.
    localparam logic [MAX_REGS-1:0] STROBE_IDLE = 16'hFFFF;

    typedef enum logic [1:0] {
        OP_MOVE    = 2'd0,
        OP_LOAD16  = 2'd1,
        OP_STORE16 = 2'd2,
        OP_ADDR    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH1  = 2'd1,
        ST_PH2  = 2'd2
    } state_e;

endpackage

// File: rtl/xfer_ctrl_if.sv
// Command handshake and per-register strobe bundle between decode and the register bank.
interface xfer_ctrl_if #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
) ();
    import xfer_ctrl_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    op_e                 cmd_op;
    logic [SEL_W-1:0]    cmd_src;
    logic [SEL_W-1:0]    cmd_dst;
    logic                done;
    logic                err;
    logic [NUM_REGS-1:0] assert_xfer_n;
    logic [NUM_REGS-1:0] load_xfer_n;
    logic [NUM_REGS-1:0] assert_addr_n;
    logic [NUM_REGS-1:0] assertlow_main_n;
    logic [NUM_REGS-1:0] asserthigh_main_n;
    logic [NUM_REGS-1:0] loadlow_main_n;
    logic [NUM_REGS-1:0] loadhigh_main_n;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, done, err,
        input  assert_xfer_n, load_xfer_n, assert_addr_n,
        input  assertlow_main_n, asserthigh_main_n, loadlow_main_n, loadhigh_main_n
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, done, err,
        output assert_xfer_n, load_xfer_n, assert_addr_n,
        output assertlow_main_n, asserthigh_main_n, loadlow_main_n, loadhigh_main_n
    );

endinterface

// File: rtl/xfer_strobe_dec.sv
// Active-low one-hot decoder for one strobe kind; indices at or above NUM_REGS select nothing.
module xfer_strobe_dec
    import xfer_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    idx,
    output logic [NUM_REGS-1:0] strobe_n
);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        assign strobe_n[i] = (en && (idx == SEL_W'(i))) ? 1'b0 : STROBE_IDLE[i];
    end

endmodule

// File: rtl/xfer_ctrl.sv
// Transfer-register strobe sequencer: one command at a time, one or two strobe phases.
// Optional XFER_CTRL_ERR_EN rejects self-moves and out-of-range indices with an err pulse.
module xfer_ctrl
    import xfer_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic        clk,
    input  logic        rst_n,
    xfer_ctrl_if.slave  bus
);

    state_e           state_r;
    state_e           state_s;
    op_e              op_r;
    logic [SEL_W-1:0] src_r;
    logic [SEL_W-1:0] dst_r;
    logic             accept_s;
    logic             reject_s;
    logic             ph1_s;
    logic             ph2_s;

`ifdef XFER_CTRL_ERR_EN
    logic err_r;

    function automatic logic idx_bad(input logic [SEL_W-1:0] idx);
        return ({1'b0, idx} >= (SEL_W+1)'(NUM_REGS));
    endfunction

    // Classify the presented command; only the indices the op actually uses are checked.
    always_comb begin
        reject_s = 1'b0;
        case (bus.cmd_op)
            OP_MOVE:    reject_s = (bus.cmd_src == bus.cmd_dst) || idx_bad(bus.cmd_src)
                                   || idx_bad(bus.cmd_dst);
            OP_LOAD16:  reject_s = idx_bad(bus.cmd_dst);
            OP_STORE16: reject_s = idx_bad(bus.cmd_src);
            OP_ADDR:    reject_s = idx_bad(bus.cmd_src);
            default:    reject_s = 1'b0;
        endcase
    end

    // Rejected commands are consumed in IDLE and reported one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_r == ST_IDLE) && bus.cmd_valid && reject_s;
        end
    end

    assign bus.err = err_r;
`else
    assign reject_s = 1'b0;
    assign bus.err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the two-phase ops are the only path through PH2.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid && !reject_s) begin
                    accept_s = 1'b1;
                    state_s  = ST_PH1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_PH1: begin
                if ((op_r == OP_LOAD16) || (op_r == OP_STORE16)) begin
                    state_s = ST_PH2;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PH2:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Command capture; strobes decode only from these registered fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= OP_MOVE;
            src_r <= '0;
            dst_r <= '0;
        end else if (accept_s) begin
            op_r  <= bus.cmd_op;
            src_r <= bus.cmd_src;
            dst_r <= bus.cmd_dst;
        end else begin
            op_r  <= op_r;
            src_r <= src_r;
            dst_r <= dst_r;
        end
    end

    assign ph1_s         = (state_r == ST_PH1);
    assign ph2_s         = (state_r == ST_PH2);
    assign bus.cmd_ready = (state_r == ST_IDLE);
    assign bus.done      = (ph1_s && ((op_r == OP_MOVE) || (op_r == OP_ADDR))) || ph2_s;

    xfer_strobe_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_assert_xfer (
        .en(ph1_s && (op_r == OP_MOVE)), .idx(src_r), .strobe_n(bus.assert_xfer_n));
    xfer_strobe_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_load_xfer (
        .en(ph1_s && (op_r == OP_MOVE)), .idx(dst_r), .strobe_n(bus.load_xfer_n));
    xfer_strobe_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_assert_addr (
        .en(ph1_s && (op_r == OP_ADDR)), .idx(src_r), .strobe_n(bus.assert_addr_n));
    xfer_strobe_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_assertlow (
        .en(ph1_s && (op_r == OP_STORE16)), .idx(src_r), .strobe_n(bus.assertlow_main_n));
    xfer_strobe_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_asserthigh (
        .en(ph2_s && (op_r == OP_STORE16)), .idx(src_r), .strobe_n(bus.asserthigh_main_n));
    xfer_strobe_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_loadlow (
        .en(ph1_s && (op_r == OP_LOAD16)), .idx(dst_r), .strobe_n(bus.loadlow_main_n));
    xfer_strobe_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_loadhigh (
        .en(ph2_s && (op_r == OP_LOAD16)), .idx(dst_r), .strobe_n(bus.loadhigh_main_n));

endmodule

// File: tb/tb_xfer_ctrl.sv
// Table-driven bench for xfer_ctrl with a small register-bank model on the strobes.
module tb_xfer_ctrl;
    import xfer_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0] ax, lx, aa, al, ah, ll, lh;
        logic       done, err, ready;
    } snap_t;

    typedef struct {
        op_e        op;
        logic [1:0] src, dst;
        logic [3:0] ax, lx, aa, al, ah, ll, lh;
        bit         two;
    } vec_t;

    localparam snap_t IDLE_S = '{ax: 4'hF, lx: 4'hF, aa: 4'hF, al: 4'hF, ah: 4'hF,
                                 ll: 4'hF, lh: 4'hF, done: 1'b0, err: 1'b0, ready: 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  main_in = 8'h00;
    logic [15:0] bank [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] xfer_bus;
    snap_t       exp_q [$];
    vec_t        tbl [9];
    int          n_vec = 0;
    int          n_bad = 0;

    xfer_ctrl_if #(.NUM_REGS(4)) bus ();
    xfer_ctrl #(.NUM_REGS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always_comb begin
        xfer_bus = 16'h0000;
        for (int i = 0; i < 4; i++)
            if (!bus.assert_xfer_n[i]) xfer_bus = bank[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!bus.load_xfer_n[i])     bank[i]       <= xfer_bus;
            if (!bus.loadlow_main_n[i])  bank[i][7:0]  <= main_in;
            if (!bus.loadhigh_main_n[i]) bank[i][15:8] <= main_in;
        end
    end

    function automatic snap_t sample();
        snap_t s;
        s.ax = bus.assert_xfer_n;     s.lx = bus.load_xfer_n;
        s.aa = bus.assert_addr_n;     s.al = bus.assertlow_main_n;
        s.ah = bus.asserthigh_main_n; s.ll = bus.loadlow_main_n;
        s.lh = bus.loadhigh_main_n;   s.done = bus.done;
        s.err = bus.err;              s.ready = bus.cmd_ready;
        return s;
    endfunction

    task automatic check(input string name);
        snap_t act;
        snap_t exp;
        act = sample();
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", name, act, exp);
            end
        end
    endtask

    task automatic check_reg(input string name, input int idx, input logic [15:0] exp);
        n_vec++;
        if (bank[idx] !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, bank[idx], exp);
        end
    endtask

    task automatic drive(input op_e op, input logic [1:0] src, input logic [1:0] dst);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
    endtask

    // Entered and left at a negedge so consecutive vectors run back to back.
    task automatic run_vec(input string name, input vec_t v);
        snap_t e;
        drive(v.op, v.src, v.dst);
        e = IDLE_S; e.ready = 1'b0; e.ax = v.ax; e.lx = v.lx; e.aa = v.aa;
        e.al = v.al; e.ll = v.ll; e.done = !v.two;
        exp_q.push_back(e);
        if (v.two) begin
            e = IDLE_S; e.ready = 1'b0; e.ah = v.ah; e.lh = v.lh; e.done = 1'b1;
            exp_q.push_back(e);
        end
        exp_q.push_back(IDLE_S);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        main_in = 8'h34;
        @(negedge clk); check({name, "_ph1"});
        if (v.two) begin
            @(posedge clk); #1;
            main_in = 8'h12;
            @(negedge clk); check({name, "_ph2"});
        end
        @(negedge clk); check({name, "_idle"});
    endtask

    initial begin
        snap_t e;
        vec_t  v;
        tbl[0] = '{op: OP_MOVE,    src: 2'd1, dst: 2'd3, ax: 4'b1101, lx: 4'b0111, aa: 4'hF,
                   al: 4'hF, ah: 4'hF, ll: 4'hF, lh: 4'hF, two: 1'b0};
        tbl[1] = '{op: OP_MOVE,    src: 2'd0, dst: 2'd2, ax: 4'b1110, lx: 4'b1011, aa: 4'hF,
                   al: 4'hF, ah: 4'hF, ll: 4'hF, lh: 4'hF, two: 1'b0};
        tbl[2] = '{op: OP_ADDR,    src: 2'd2, dst: 2'd1, ax: 4'hF, lx: 4'hF, aa: 4'b1011,
                   al: 4'hF, ah: 4'hF, ll: 4'hF, lh: 4'hF, two: 1'b0};
        tbl[3] = '{op: OP_ADDR,    src: 2'd0, dst: 2'd3, ax: 4'hF, lx: 4'hF, aa: 4'b1110,
                   al: 4'hF, ah: 4'hF, ll: 4'hF, lh: 4'hF, two: 1'b0};
        tbl[4] = '{op: OP_STORE16, src: 2'd3, dst: 2'd0, ax: 4'hF, lx: 4'hF, aa: 4'hF,
                   al: 4'b0111, ah: 4'b0111, ll: 4'hF, lh: 4'hF, two: 1'b1};
        tbl[5] = '{op: OP_STORE16, src: 2'd1, dst: 2'd2, ax: 4'hF, lx: 4'hF, aa: 4'hF,
                   al: 4'b1101, ah: 4'b1101, ll: 4'hF, lh: 4'hF, two: 1'b1};
        tbl[6] = '{op: OP_LOAD16,  src: 2'd3, dst: 2'd0, ax: 4'hF, lx: 4'hF, aa: 4'hF,
                   al: 4'hF, ah: 4'hF, ll: 4'b1110, lh: 4'b1110, two: 1'b1};
        tbl[7] = '{op: OP_LOAD16,  src: 2'd1, dst: 2'd2, ax: 4'hF, lx: 4'hF, aa: 4'hF,
                   al: 4'hF, ah: 4'hF, ll: 4'b1011, lh: 4'b1011, two: 1'b1};
        tbl[8] = '{op: OP_MOVE,    src: 2'd2, dst: 2'd1, ax: 4'b1011, lx: 4'b1101, aa: 4'hF,
                   al: 4'hF, ah: 4'hF, ll: 4'hF, lh: 4'hF, two: 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_MOVE;
        bus.cmd_src   = 2'd0;
        bus.cmd_dst   = 2'd0;

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk);
        exp_q.push_back(IDLE_S); check("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(IDLE_S); check("reset_release");

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
            if (i == 1) check_reg("move_data", 3, 16'h2222);
            if (i == 7) check_reg("load16_data", 2, 16'h1234);
            if (i == 8) check_reg("move_loaded", 1, 16'h1234);
        end

        // Back-pressure: ADDR held behind a STORE16 until the controller returns to IDLE.
        drive(OP_STORE16, 2'd0, 2'd3);
        e = IDLE_S; e.ready = 1'b0; e.al = 4'b1110; exp_q.push_back(e);
        e = IDLE_S; e.ready = 1'b0; e.ah = 4'b1110; e.done = 1'b1; exp_q.push_back(e);
        exp_q.push_back(IDLE_S);
        e = IDLE_S; e.ready = 1'b0; e.aa = 4'b1011; e.done = 1'b1; exp_q.push_back(e);
        exp_q.push_back(IDLE_S);
        @(posedge clk); #1;
        drive(OP_ADDR, 2'd2, 2'd0);
        @(negedge clk); check("bp_ph1");
        @(negedge clk); check("bp_ph2");
        @(negedge clk); check("bp_ready");
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk); check("bp_addr");
        @(negedge clk); check("bp_idle");

        // Reset during PH1 of a LOAD16 clears strobes without a clock edge.
        drive(OP_LOAD16, 2'd0, 2'd1);
        e = IDLE_S; e.ready = 1'b0; e.ll = 4'b1101; exp_q.push_back(e);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk); check("rst_mid_ph1");
        #2 rst_n = 1'b0;
        #1 exp_q.push_back(IDLE_S); check("rst_mid_async");
        @(negedge clk); exp_q.push_back(IDLE_S); check("rst_mid_held");
        rst_n = 1'b1;
        @(negedge clk); exp_q.push_back(IDLE_S); check("rst_mid_no_ph2");

        // Self-move: executes normally by default, rejected with err when checking is enabled.
`ifdef XFER_CTRL_ERR_EN
        drive(OP_MOVE, 2'd1, 2'd1);
        e = IDLE_S; e.err = 1'b1; exp_q.push_back(e);
        exp_q.push_back(IDLE_S);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk); check("self_move_err");
        @(negedge clk); check("self_move_err_clear");
`else
        v = '{op: OP_MOVE, src: 2'd1, dst: 2'd1, ax: 4'b1101, lx: 4'b1101, aa: 4'hF,
              al: 4'hF, ah: 4'hF, ll: 4'hF, lh: 4'hF, two: 1'b0};
        run_vec("self_move", v);
        check_reg("self_move_data", 1, 16'h1234);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
